// File: rtl/core_region_readout_arb.sv
// rtl/core_region_readout_arb.sv - N-region trigger readout arbiter (fixed/RR), word limit, optional HitOr counters (CORE_REGION_HITOR_CNT_EN)
module core_region_readout_arb #(
    parameter int NREG      = 16,
    parameter int DATA_W    = 16,
    parameter int TID_W     = 5,
    parameter int MAX_WORDS = 32,
    parameter int CNT_W     = 16,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int CW = $clog2(MAX_WORDS + 1)
) (
    input  logic                   Clk,
    input  logic                   Reset_b,
    input  logic                   Start,
    input  logic [TID_W-1:0]       TrigIdReq,
    input  logic                   RrMode,
    input  logic [NREG-1:0]        RegReq,
    input  logic [NREG*DATA_W-1:0] RegData,
    output logic [NREG-1:0]        RegAck,
    input  logic                   Read,
    output logic [DATA_W-1:0]      DataOut,
    output logic [AW-1:0]          RegAddrOut,
    output logic [TID_W-1:0]       TagOut,
    output logic                   Valid,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Overflow,
    input  logic [NREG-1:0]        HitOr,
    input  logic [AW-1:0]          CntSel,
    input  logic                   CntClr,
    output logic [CNT_W-1:0]       CntOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_GRANT,
        S_ACKWAIT,
        S_FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              start_load;
    logic              grant_load;
    logic              ack_fire;

    logic [AW-1:0]     rr_ptr;
    logic [CW-1:0]     word_cnt;
    logic [CW-1:0]     word_cnt_inc;
    logic              ovf_flag;
    logic              at_limit;

    logic [DATA_W-1:0] reg_word [NREG];
    logic [AW-1:0]     scan_ptr;
    logic [AW-1:0]     win_idx;
    logic [AW-1:0]     cand_idx;
    logic              win_found;
    int                cand;
    logic [NREG-1:0]   ack_onehot;

    for (genvar g = 0; g < NREG; g++) begin : g_word
        assign reg_word[g] = RegData[g*DATA_W +: DATA_W];
    end

    // Search starts at the RR pointer (or 0 in fixed mode) and wraps past NREG-1.
    always_comb begin
        scan_ptr  = RrMode ? rr_ptr : '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NREG; i++) begin
            cand = int'(scan_ptr) + i;
            if (cand >= NREG) begin
                cand = cand - NREG;
            end
            cand_idx = AW'(cand);
            if (!win_found && RegReq[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            ack_onehot[i] = (RegAddrOut == AW'(i));
        end
    end

    assign word_cnt_inc = word_cnt + CW'(1);
    assign at_limit     = (word_cnt_inc == CW'(MAX_WORDS));

    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_load = 1'b0;
        grant_load = 1'b0;
        ack_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_load = 1'b1;
                    state_nxt  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (win_found) begin
                    grant_load = 1'b1;
                    state_nxt  = S_GRANT;
                end else begin
                    state_nxt  = S_FINISH;
                end
            end
            S_GRANT: begin
                if (Read) begin
                    ack_fire  = 1'b1;
                    state_nxt = at_limit ? S_FINISH : S_ACKWAIT;
                end
            end
            S_ACKWAIT: state_nxt = S_SCAN;
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // RegAck is registered, so it is high during ACKWAIT (or FINISH on the last word).
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            TagOut     <= '0;
            DataOut    <= '0;
            RegAddrOut <= '0;
            Valid      <= 1'b0;
            RegAck     <= '0;
            rr_ptr     <= '0;
            word_cnt   <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            RegAck <= '0;
            if (start_load) begin
                TagOut   <= TrigIdReq;
                word_cnt <= '0;
                ovf_flag <= 1'b0;
            end
            if (grant_load) begin
                DataOut    <= reg_word[win_idx];
                RegAddrOut <= win_idx;
                Valid      <= 1'b1;
            end
            if (ack_fire) begin
                Valid    <= 1'b0;
                RegAck   <= ack_onehot;
                word_cnt <= word_cnt_inc;
                if (at_limit) begin
                    ovf_flag <= 1'b1;
                end
                if (RrMode) begin
                    rr_ptr <= (RegAddrOut == AW'(NREG - 1)) ? '0 : RegAddrOut + AW'(1);
                end
            end
        end
    end

    assign Busy     = (state != S_IDLE);
    assign Done     = (state == S_FINISH);
    assign Overflow = (state == S_FINISH) && ovf_flag;

`ifdef CORE_REGION_HITOR_CNT_EN
    logic [NREG-1:0]  hitor_q;
    logic [CNT_W-1:0] hit_cnt [NREG];
    logic [CNT_W-1:0] cnt_out_q;

    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            hitor_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            hitor_q <= HitOr;
            for (int i = 0; i < NREG; i++) begin
                // Clear wins over a coincident edge.
                if (CntClr) begin
                    hit_cnt[i] <= '0;
                end else if (HitOr[i] && !hitor_q[i] && (hit_cnt[i] != '1)) begin
                    hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            cnt_out_q <= '0;
        end else if (32'(CntSel) < NREG) begin
            cnt_out_q <= hit_cnt[CntSel];
        end else begin
            cnt_out_q <= '0;
        end
    end

    assign CntOut = cnt_out_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{HitOr, CntSel, CntClr};
    assign CntOut = '0;
`endif

endmodule

// File: tb/tb_core_region_readout_arb.sv
// tb/tb_core_region_readout_arb.sv - directed self-checking bench for core_region_readout_arb
module tb_core_region_readout_arb;

    localparam int NREG   = 16;
    localparam int DATA_W = 16;
    localparam int TID_W  = 5;
    localparam int MAXW   = 4;
    localparam int CNT_W  = 4;
`ifdef CORE_REGION_HITOR_CNT_EN
    localparam logic [CNT_W-1:0] EXP_SAT = 4'd15;
`else
    localparam logic [CNT_W-1:0] EXP_SAT = 4'd0;
`endif

    logic                   Clk;
    logic                   Reset_b;
    logic                   Start;
    logic [TID_W-1:0]       TrigIdReq;
    logic                   RrMode;
    logic [NREG-1:0]        RegReq;
    logic [NREG*DATA_W-1:0] RegData;
    logic [NREG-1:0]        RegAck;
    logic                   Read;
    logic [DATA_W-1:0]      DataOut;
    logic [3:0]             RegAddrOut;
    logic [TID_W-1:0]       TagOut;
    logic                   Valid;
    logic                   Busy;
    logic                   Done;
    logic                   Overflow;
    logic [NREG-1:0]        HitOr;
    logic [3:0]             CntSel;
    logic                   CntClr;
    logic [CNT_W-1:0]       CntOut;

    core_region_readout_arb #(
        .NREG(NREG), .DATA_W(DATA_W), .TID_W(TID_W), .MAX_WORDS(MAXW), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset_b(Reset_b), .Start(Start), .TrigIdReq(TrigIdReq),
        .RrMode(RrMode), .RegReq(RegReq), .RegData(RegData), .RegAck(RegAck),
        .Read(Read), .DataOut(DataOut), .RegAddrOut(RegAddrOut), .TagOut(TagOut),
        .Valid(Valid), .Busy(Busy), .Done(Done), .Overflow(Overflow),
        .HitOr(HitOr), .CntSel(CntSel), .CntClr(CntClr), .CntOut(CntOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int pend [NREG];
    logic [DATA_W-1:0] wd [$];
    logic [3:0]        wa [$];
    logic [TID_W-1:0]  wt [$];
    logic [NREG-1:0]   ak [$];
    logic              got_ovf;
    logic [DATA_W-1:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Region r presents word 0xDr0n where n is its remaining word count.
    task automatic update_regions();
        for (int r = 0; r < NREG; r++) begin
            RegReq[r] = (pend[r] != 0);
            RegData[r*DATA_W +: DATA_W] = 16'hD000 | DATA_W'(r << 8) | DATA_W'(pend[r] & 8'hFF);
        end
    endtask

    task automatic tick();
        logic [NREG-1:0] a;
        a = RegAck;
        @(posedge Clk);
        #1;
        for (int r = 0; r < NREG; r++) begin
            if (a[r] && pend[r] > 0) pend[r]--;
        end
        update_regions();
    endtask

    task automatic do_start(input logic [TID_W-1:0] tid);
        wd.delete(); wa.delete(); wt.delete(); ak.delete();
        got_ovf   = 1'b0;
        TrigIdReq = tid;
        Start     = 1'b1;
        tick();
        Start     = 1'b0;
    endtask

    task automatic collect(input int budget);
        bit fin;
        fin = 0;
        for (int k = 0; k < budget && !fin; k++) begin
            if (Valid && Read) begin
                wd.push_back(DataOut); wa.push_back(RegAddrOut); wt.push_back(TagOut);
            end
            if (RegAck != '0) ak.push_back(RegAck);
            if (Done) begin
                fin = 1;
                got_ovf = Overflow;
            end
            tick();
        end
        check("done_seen", 64'(fin), 64'd1);
    endtask

    initial begin
        Reset_b = 1'b1; Start = 1'b0; TrigIdReq = '0; RrMode = 1'b0; Read = 1'b0;
        HitOr = '0; CntSel = '0; CntClr = 1'b0;
        for (int r = 0; r < NREG; r++) pend[r] = 0;
        update_regions();
        #2 Reset_b = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", 64'(Valid), 0);
        check("rst_busy", 64'(Busy), 0);
        check("rst_done", 64'(Done), 0);
        check("rst_ovf", 64'(Overflow), 0);
        check("rst_ack", 64'(RegAck), 0);
        check("rst_tag", 64'(TagOut), 0);
        check("rst_data", 64'(DataOut), 0);
        check("rst_cnt", 64'(CntOut), 0);
        @(negedge Clk) Reset_b = 1'b1;
        @(posedge Clk); #1;

        // Fixed priority: regions 2 and 5, one word each
        pend[2] = 1; pend[5] = 1; update_regions();
        Read = 1'b1;
        do_start(5'd7);
        check("t1_scan_valid", 64'(Valid), 0);
        check("t1_busy", 64'(Busy), 1);
        collect(60);
        check("t1_nwords", 64'(wd.size()), 2);
        check("t1_w0", 64'(wd[0]), 64'hD201);
        check("t1_a0", 64'(wa[0]), 2);
        check("t1_w1", 64'(wd[1]), 64'hD501);
        check("t1_a1", 64'(wa[1]), 5);
        check("t1_tag", 64'(wt[0]), 7);
        check("t1_nacks", 64'(ak.size()), 2);
        check("t1_ack0", 64'(ak[0]), 64'h0004);
        check("t1_ack1", 64'(ak[1]), 64'h0020);
        check("t1_ovf", 64'(got_ovf), 0);
        check("t1_busy_after", 64'(Busy), 0);
        check("t1_done_pulse", 64'(Done), 0);

        // Round robin: first put pointer at 3, then regions 1 and 4 wrap
        RrMode = 1'b1;
        pend[2] = 1; update_regions();
        do_start(5'd3);
        tick();
        check("t2_lat_valid", 64'(Valid), 1);
        check("t2_lat_addr", 64'(RegAddrOut), 2);
        collect(60);
        pend[1] = 1; pend[4] = 1; update_regions();
        do_start(5'd10);
        collect(60);
        check("t2_nwords", 64'(wa.size()), 2);
        check("t2_a0", 64'(wa[0]), 4);
        check("t2_a1", 64'(wa[1]), 1);
        check("t2_ack0", 64'(ak[0]), 64'h0010);
        check("t2_ack1", 64'(ak[1]), 64'h0002);

        // Backpressure: Read low for 5 cycles; lower region appears mid-GRANT
        RrMode = 1'b0; Read = 1'b0;
        pend[6] = 2; update_regions();
        do_start(5'd9);
        for (int k = 0; k < 10 && !Valid; k++) tick();
        check("t3_valid", 64'(Valid), 1);
        held = DataOut;
        check("t3_data", 64'(held), 64'hD602);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin
                pend[3] = 1; update_regions();
            end
            check("t3_hold_valid", 64'(Valid), 1);
            check("t3_hold_data", 64'(DataOut), 64'(held));
            check("t3_hold_noack", 64'(RegAck), 0);
        end
        Read = 1'b1;
        tick();
        check("t3_acc_valid", 64'(Valid), 0);
        check("t3_acc_ack", 64'(RegAck), 64'h0040);
        collect(60);
        check("t3_nwords", 64'(wd.size()), 2);
        check("t3_w0", 64'(wd[0]), 64'hD301);
        check("t3_w1", 64'(wd[1]), 64'hD601);
        check("t3_nacks", 64'(ak.size()), 3);
        check("t3_ovf", 64'(got_ovf), 0);

        // Word limit: region 0 keeps requesting
        pend[0] = 10; update_regions();
        do_start(5'd31);
        collect(80);
        check("t4_nwords", 64'(wd.size()), 4);
        check("t4_w0", 64'(wd[0]), 64'hD00A);
        check("t4_w3", 64'(wd[3]), 64'hD007);
        check("t4_nacks", 64'(ak.size()), 4);
        check("t4_ovf", 64'(got_ovf), 1);
        check("t4_ovf_after", 64'(Overflow), 0);
        check("t4_busy_after", 64'(Busy), 0);
        pend[0] = 0; update_regions();

        // Start while busy ignored; reset during GRANT
        Read = 1'b0;
        pend[5] = 1; update_regions();
        do_start(5'd4);
        for (int k = 0; k < 10 && !Valid; k++) tick();
        TrigIdReq = 5'd12; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t5_tag_kept", 64'(TagOut), 4);
        check("t5_addr_kept", 64'(RegAddrOut), 5);
        check("t5_valid_kept", 64'(Valid), 1);
        #2 Reset_b = 1'b0;
        #1;
        check("t5_rst_valid", 64'(Valid), 0);
        check("t5_rst_busy", 64'(Busy), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t5_rst_noack", 64'(RegAck), 0);
            check("t5_rst_nodone", 64'(Done), 0);
        end
        @(negedge Clk) Reset_b = 1'b1;
        @(posedge Clk); #1;
        RrMode = 1'b1; Read = 1'b1;
        pend[1] = 1; update_regions();
        do_start(5'd2);
        collect(60);
        check("t5_nwords", 64'(wa.size()), 2);
        check("t5_a0", 64'(wa[0]), 1);
        check("t5_a1", 64'(wa[1]), 5);
        check("t5_tag", 64'(wt[0]), 2);
        check("t5_ovf", 64'(got_ovf), 0);

        // HitOr counters: 20 pulses on region 3
        CntSel = 4'd3;
        for (int p = 0; p < 20; p++) begin
            HitOr[3] = 1'b1; tick();
            HitOr[3] = 1'b0; tick();
        end
        tick();
        check("cnt_sat", 64'(CntOut), 64'(EXP_SAT));
        CntSel = 4'd2;
        tick(); tick();
        check("cnt_other", 64'(CntOut), 0);
        CntSel = 4'd3;
        HitOr[3] = 1'b1; CntClr = 1'b1;
        tick();
        HitOr[3] = 1'b0; CntClr = 1'b0;
        tick(); tick();
        check("cnt_clr", 64'(CntOut), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_region_readout_arb.md
Name: core_region_readout_arb

Overview:
- Parametrised successor to the fixed 16-region token chain in the digital core.
- Arbitrates N pixel regions that hold hit data for one requested trigger ID, and streams their words to the core/column readout with a valid/ready handshake.
- Adds selectable fixed-priority or round-robin arbitration, a per-trigger word limit with overflow flag, and optional per-region HitOr counters.

Parameters:
- NREG, 16, number of pixel regions arbitrated (2..64)
- DATA_W, 16, width of one region data word
- TID_W, 5, trigger ID width
- MAX_WORDS, 32, max words emitted per trigger before forced stop (1..255)
- CNT_W, 16, HitOr counter width (only with the optional feature)

Ports:
- Clk  in  1  core clock (delayed core clock domain)
- Reset_b  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse: begin readout of TrigIdReq
- TrigIdReq  in  TID_W  trigger ID to read; sampled on accepted Start
- RrMode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- RegReq  in  NREG  region r has a word for the current trigger
- RegData  in  NREG*DATA_W  region words; region r occupies bits [r*DATA_W +: DATA_W]
- RegAck  out  NREG  one-hot, one-cycle pulse: region word consumed
- Read  in  1  downstream ready
- DataOut  out  DATA_W  selected word
- RegAddrOut  out  clog2(NREG)  index of the granted region
- TagOut  out  TID_W  latched trigger ID
- Valid  out  1  DataOut, RegAddrOut and TagOut are valid
- Busy  out  1  readout in progress (state != IDLE)
- Done  out  1  one-cycle pulse: trigger readout finished
- Overflow  out  1  set with Done when MAX_WORDS was reached
- HitOr  in  NREG  per-region HitOr (used only with the optional feature)
- CntSel  in  clog2(NREG)  counter select (optional feature)
- CntClr  in  1  synchronous clear of all counters (optional feature)
- CntOut  out  CNT_W  selected counter value (optional feature)

Behaviour:
- Reset (Reset_b=0, asynchronous): state IDLE, all outputs 0, RR pointer 0, word count 0, latched tag 0, counters 0.
- FSM states: IDLE, SCAN, GRANT, ACKWAIT, FINISH.
- IDLE:
  - Start=1: latch TrigIdReq into TagOut, clear word count, go to SCAN.
  - Start is ignored in every state other than IDLE.
- SCAN:
  - If RegReq is nonzero: select winner. Fixed mode takes the lowest set index. RR mode takes the first set index at or after the pointer, wrapping at NREG-1 to 0. Register DataOut, RegAddrOut and Valid=1, go to GRANT.
  - If RegReq is zero: go to FINISH.
  - Latency: Start at cycle t gives Valid at t+2 at the earliest.
- GRANT:
  - Valid holds and outputs are stable until Read=1.
  - On Valid&Read: Valid=0, RegAck[winner]=1 for exactly one cycle, word count +1.
  - RR mode: pointer = winner+1, mod NREG.
  - If the new count equals MAX_WORDS, go to FINISH with the overflow flag set; otherwise go to ACKWAIT.
- ACKWAIT:
  - Lasts exactly one cycle so the acked region can update RegReq; RegReq is not sampled here.
  - Then go to SCAN.
- FINISH:
  - Done=1 for one cycle; Overflow mirrors the overflow flag in the same cycle and is 0 otherwise.
  - Go to IDLE. Busy=0 from the next cycle.
- RegReq changing during GRANT does not change the granted region or DataOut.
- A winner is granted only if its RegReq bit was 1 at the SCAN sample.
- Word count width is clog2(MAX_WORDS+1) and it never wraps.
- Reset_b asserted mid-readout aborts immediately. No Done and no RegAck are issued; the FSM restarts in IDLE.
- NREG=1: arbitration degenerates to that region; RR and fixed modes behave identically.

Optional Feature:
- Macro: CORE_REGION_HITOR_CNT_EN.
- Enabled:
  - One CNT_W saturating counter per region.
  - Each counter increments on a HitOr rising edge, detected with one register stage.
  - Counters saturate at all-ones.
  - CntClr zeroes all counters. If a clear and an edge occur in the same cycle, the counter ends at 0.
  - CntOut = counter[CntSel], registered, 1-cycle latency.
  - CntSel >= NREG returns 0.
- Disabled: no counter logic; CntOut is tied to 0; HitOr, CntSel and CntClr are unused.

Test Plan:
- Fixed mode, RegReq=0x0024 (one word each), Read=1, Start with TrigIdReq=7:
  - Words from region 2 then region 5.
  - TagOut=7, RegAck pulses 0x0004 then 0x0020, Done=1, Overflow=0.
- RR mode, pointer at 3, regions 1 and 4 requesting → region 4 granted first, then region 1 (wrap-around).
- Read held 0 for 5 cycles in GRANT → Valid and DataOut stable, no RegAck; ack pulses the cycle after Read=1.
- MAX_WORDS=4, region 0 keeps RegReq=1 → exactly 4 words, then Done=1 with Overflow=1.
- Start while Busy is ignored; Reset_b=0 during GRANT → Valid=0, no RegAck, no Done; a following Start works normally.
- With CORE_REGION_HITOR_CNT_EN, CNT_W=4: 20 HitOr pulses on region 3 give CntSel=3 → CntOut=15 (saturated); CntClr → 0.
